// File: rtl/ialu_pipe.sv
// ialu_pipe: pipelined integer ALU for the execute cluster.
// Results are computed combinationally at the input and captured into stage 0.
// Later stages only carry the uop forward under elastic valid/ready flow control,
// with speculative kill, branch-resolve mask clearing and flush.
module ialu_pipe #(
    parameter int XLEN        = 64,
    parameter int STAGES      = 2,
    parameter int SPEC_STATES = 8,
    parameter int PRD_W       = 7,
    parameter int ROB_W       = 6
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   kill_en,
    input  logic [SPEC_STATES-1:0] kill_mask,
    input  logic                   resolve_en,
    input  logic [SPEC_STATES-1:0] resolve_mask,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [3:0]             in_op,
    input  logic                   in_word,
    input  logic [XLEN-1:0]        in_op1,
    input  logic [XLEN-1:0]        in_op2,
    input  logic [SPEC_STATES-1:0] in_killmask,
    input  logic [PRD_W-1:0]       in_prd,
    input  logic                   in_prd_type,
    input  logic                   in_reg_we,
    input  logic [ROB_W-1:0]       in_rob,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [XLEN-1:0]        out_value,
    output logic [PRD_W-1:0]       out_prd,
    output logic                   out_prd_type,
    output logic                   out_reg_we,
    output logic [ROB_W-1:0]       out_rob,
    output logic [SPEC_STATES-1:0] out_killmask,
    output logic                   wakeup_valid
);

    localparam int SH = $clog2(XLEN);

    typedef enum logic [3:0] {
        OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR, OP_SRL, OP_SRA,
        OP_OR, OP_AND, OP_MIN, OP_MAX, OP_MINU, OP_MAXU, OP_ROL, OP_ROR
    } alu_op_e;

    alu_op_e          op;
    logic [XLEN-1:0]  alu_res;
    logic [SH-1:0]    shamt;
    logic [SH-1:0]    shamt_neg;
    logic             signed_lt;
    logic             unsigned_lt;
    logic [31:0]      w_a;
    logic [31:0]      w_b;
    logic [4:0]       w_sh;
    logic [4:0]       w_sh_neg;
    logic [31:0]      w_res;
    logic             word_op;

    // Per-stage pipeline state
    logic [STAGES-1:0]      st_valid;
    logic [XLEN-1:0]        st_value    [STAGES];
    logic [PRD_W-1:0]       st_prd      [STAGES];
    logic                   st_prd_type [STAGES];
    logic                   st_reg_we   [STAGES];
    logic [ROB_W-1:0]       st_rob      [STAGES];
    logic [SPEC_STATES-1:0] st_mask     [STAGES];

    // What each stage would load when it moves: the input for stage 0, the previous stage otherwise
    logic [STAGES-1:0]      up_valid;
    logic [XLEN-1:0]        up_value    [STAGES];
    logic [PRD_W-1:0]       up_prd      [STAGES];
    logic                   up_prd_type [STAGES];
    logic                   up_reg_we   [STAGES];
    logic [ROB_W-1:0]       up_rob      [STAGES];
    logic [SPEC_STATES-1:0] up_mask     [STAGES];

    logic [STAGES-1:0] adv;
    logic [STAGES-1:0] can_load;

    assign op = alu_op_e'(in_op);

    function automatic logic is_killed(input logic [SPEC_STATES-1:0] m,
                                       input logic en,
                                       input logic [SPEC_STATES-1:0] km);
        return en && ((m & km) != '0);
    endfunction

    function automatic logic [SPEC_STATES-1:0] resolved(input logic [SPEC_STATES-1:0] m,
                                                        input logic en,
                                                        input logic [SPEC_STATES-1:0] rm);
        return en ? (m & ~rm) : m;
    endfunction

    // ALU datapath; rotates use x<<n | x>>(-n) so a zero amount needs no special case
    always_comb begin
        signed_lt   = $signed(in_op1) < $signed(in_op2);
        unsigned_lt = in_op1 < in_op2;
        shamt       = in_op2[SH-1:0];
        shamt_neg   = -shamt;
        w_a         = in_op1[31:0];
        w_b         = in_op2[31:0];
        w_sh        = in_op2[4:0];
        w_sh_neg    = -w_sh;
        word_op     = (XLEN == 64) && in_word &&
                      (op inside {OP_ADD, OP_SUB, OP_SLL, OP_SRL, OP_SRA, OP_ROL, OP_ROR});
        case (op)
            OP_ADD:  w_res = w_a + w_b;
            OP_SUB:  w_res = w_a - w_b;
            OP_SLL:  w_res = w_a << w_sh;
            OP_SRL:  w_res = w_a >> w_sh;
            OP_SRA:  w_res = $signed(w_a) >>> w_sh;
            OP_ROL:  w_res = (w_a << w_sh) | (w_a >> w_sh_neg);
            OP_ROR:  w_res = (w_a >> w_sh) | (w_a << w_sh_neg);
            default: w_res = w_a;
        endcase
        case (op)
            OP_ADD:  alu_res = in_op1 + in_op2;
            OP_SUB:  alu_res = in_op1 - in_op2;
            OP_SLL:  alu_res = in_op1 << shamt;
            OP_SLT:  alu_res = {{(XLEN-1){1'b0}}, signed_lt};
            OP_SLTU: alu_res = {{(XLEN-1){1'b0}}, unsigned_lt};
            OP_XOR:  alu_res = in_op1 ^ in_op2;
            OP_SRL:  alu_res = in_op1 >> shamt;
            OP_SRA:  alu_res = $signed(in_op1) >>> shamt;
            OP_OR:   alu_res = in_op1 | in_op2;
            OP_AND:  alu_res = in_op1 & in_op2;
            OP_MIN:  alu_res = signed_lt ? in_op1 : in_op2;
            OP_MAX:  alu_res = signed_lt ? in_op2 : in_op1;
            OP_MINU: alu_res = unsigned_lt ? in_op1 : in_op2;
            OP_MAXU: alu_res = unsigned_lt ? in_op2 : in_op1;
            OP_ROL:  alu_res = (in_op1 << shamt) | (in_op1 >> shamt_neg);
            OP_ROR:  alu_res = (in_op1 >> shamt) | (in_op1 << shamt_neg);
            default: alu_res = '0;
        endcase
        if (word_op) begin
            alu_res = XLEN'($signed(w_res));
        end
    end

    // A stage advances when the output accepts or any stage downstream of it is empty
    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            adv[k] = out_ready;
            for (int j = k + 1; j < STAGES; j++) begin
                if (!st_valid[j]) begin
                    adv[k] = 1'b1;
                end
            end
        end
        can_load = ~st_valid | adv;
    end

    assign in_ready = can_load[0];

    // Route the upstream source of every stage
    always_comb begin
        up_valid[0]    = in_valid;
        up_value[0]    = alu_res;
        up_prd[0]      = in_prd;
        up_prd_type[0] = in_prd_type;
        up_reg_we[0]   = in_reg_we;
        up_rob[0]      = in_rob;
        up_mask[0]     = in_killmask;
        for (int k = 1; k < STAGES; k++) begin
            up_valid[k]    = st_valid[k-1];
            up_value[k]    = st_value[k-1];
            up_prd[k]      = st_prd[k-1];
            up_prd_type[k] = st_prd_type[k-1];
            up_reg_we[k]   = st_reg_we[k-1];
            up_rob[k]      = st_rob[k-1];
            up_mask[k]     = st_mask[k-1];
        end
    end

    // Stage registers: flush beats kill, kill is judged on the mask before resolve clears bits
    always_ff @(posedge clk) begin
        if (rst) begin
            st_valid <= '0;
            for (int k = 0; k < STAGES; k++) begin
                st_value[k]    <= '0;
                st_prd[k]      <= '0;
                st_prd_type[k] <= 1'b0;
                st_reg_we[k]   <= 1'b0;
                st_rob[k]      <= '0;
                st_mask[k]     <= '0;
            end
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                if (flush) begin
                    st_valid[k] <= 1'b0;
                end else if (can_load[k]) begin
                    st_valid[k]    <= up_valid[k] && !is_killed(up_mask[k], kill_en, kill_mask);
                    st_value[k]    <= up_value[k];
                    st_prd[k]      <= up_prd[k];
                    st_prd_type[k] <= up_prd_type[k];
                    st_reg_we[k]   <= up_reg_we[k];
                    st_rob[k]      <= up_rob[k];
                    st_mask[k]     <= resolved(up_mask[k], resolve_en, resolve_mask);
                end else begin
                    st_valid[k] <= st_valid[k] && !is_killed(st_mask[k], kill_en, kill_mask);
                    st_mask[k]  <= resolved(st_mask[k], resolve_en, resolve_mask);
                end
            end
        end
    end

    assign out_valid    = st_valid[STAGES-1];
    assign out_value    = st_value[STAGES-1];
    assign out_prd      = st_prd[STAGES-1];
    assign out_prd_type = st_prd_type[STAGES-1];
    assign out_reg_we   = st_reg_we[STAGES-1];
    assign out_rob      = st_rob[STAGES-1];
    assign out_killmask = st_mask[STAGES-1];
    assign wakeup_valid = out_valid && out_ready;

endmodule

// File: tb/tb_ialu_pipe.sv
// tb_ialu_pipe: scenario tasks plus a randomized stream checked against a
// behavioural ALU model and an in-order scoreboard.
module tb_ialu_pipe;

    localparam int XLEN   = 64;
    localparam int STAGES = 2;
    localparam int SPEC   = 8;
    localparam int PRD_W  = 7;
    localparam int ROB_W  = 6;

    logic             clk = 1'b0;
    logic             rst;
    logic             flush;
    logic             kill_en;
    logic [SPEC-1:0]  kill_mask;
    logic             resolve_en;
    logic [SPEC-1:0]  resolve_mask;
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       in_op;
    logic             in_word;
    logic [XLEN-1:0]  in_op1;
    logic [XLEN-1:0]  in_op2;
    logic [SPEC-1:0]  in_killmask;
    logic [PRD_W-1:0] in_prd;
    logic             in_prd_type;
    logic             in_reg_we;
    logic [ROB_W-1:0] in_rob;
    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  out_value;
    logic [PRD_W-1:0] out_prd;
    logic             out_prd_type;
    logic             out_reg_we;
    logic [ROB_W-1:0] out_rob;
    logic [SPEC-1:0]  out_killmask;
    logic             wakeup_valid;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [63:0]      value;
        logic [PRD_W-1:0] prd;
        logic [ROB_W-1:0] rob;
    } exp_t;

    exp_t sb[$];

    ialu_pipe #(
        .XLEN(XLEN), .STAGES(STAGES), .SPEC_STATES(SPEC), .PRD_W(PRD_W), .ROB_W(ROB_W)
    ) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .kill_en(kill_en), .kill_mask(kill_mask),
        .resolve_en(resolve_en), .resolve_mask(resolve_mask),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_word(in_word), .in_op1(in_op1), .in_op2(in_op2),
        .in_killmask(in_killmask), .in_prd(in_prd), .in_prd_type(in_prd_type),
        .in_reg_we(in_reg_we), .in_rob(in_rob),
        .out_valid(out_valid), .out_ready(out_ready), .out_value(out_value),
        .out_prd(out_prd), .out_prd_type(out_prd_type), .out_reg_we(out_reg_we),
        .out_rob(out_rob), .out_killmask(out_killmask), .wakeup_valid(wakeup_valid)
    );

    always #5 clk = ~clk;

    // Behavioural ALU: plain arithmetic on 64 or 32 bits, word results sign-extended
    function automatic logic [63:0] ref_alu(input logic [3:0] op, input logic word,
                                            input logic [63:0] a, input logic [63:0] b);
        int n;
        logic [31:0] x, y, r;
        logic [63:0] res;
        if (word && (op inside {4'd0, 4'd1, 4'd2, 4'd6, 4'd7, 4'd14, 4'd15})) begin
            x = a[31:0];
            y = b[31:0];
            n = int'(b[4:0]);
            case (op)
                4'd0:    r = x + y;
                4'd1:    r = x - y;
                4'd2:    r = x << n;
                4'd6:    r = x >> n;
                4'd7:    r = x[31] ? ~((~x) >> n) : (x >> n);
                4'd14:   r = (x << n) | (x >> (32 - n));
                default: r = (x >> n) | (x << (32 - n));
            endcase
            return {{32{r[31]}}, r};
        end
        n = int'(b[5:0]);
        case (op)
            4'd0:    res = a + b;
            4'd1:    res = a - b;
            4'd2:    res = a << n;
            4'd3:    res = ($signed(a) < $signed(b)) ? 64'd1 : 64'd0;
            4'd4:    res = (a < b) ? 64'd1 : 64'd0;
            4'd5:    res = a ^ b;
            4'd6:    res = a >> n;
            4'd7:    res = a[63] ? ~((~a) >> n) : (a >> n);
            4'd8:    res = a | b;
            4'd9:    res = a & b;
            4'd10:   res = ($signed(a) < $signed(b)) ? a : b;
            4'd11:   res = ($signed(a) < $signed(b)) ? b : a;
            4'd12:   res = (a < b) ? a : b;
            4'd13:   res = (a < b) ? b : a;
            4'd14:   res = (a << n) | (a >> (64 - n));
            default: res = (a >> n) | (a << (64 - n));
        endcase
        return res;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in_valid = 1'b0; flush = 1'b0; kill_en = 1'b0; resolve_en = 1'b0;
        kill_mask = '0; resolve_mask = '0;
    endtask

    task automatic drive(input logic [3:0] op, input logic word, input logic [63:0] a,
                         input logic [63:0] b, input logic [SPEC-1:0] m, input logic [ROB_W-1:0] rob);
        in_valid = 1'b1; in_op = op; in_word = word; in_op1 = a; in_op2 = b;
        in_killmask = m; in_rob = rob; in_prd = PRD_W'(rob + 6'd3);
        in_prd_type = rob[0]; in_reg_we = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1; out_ready = 1'b0; idle();
        drive(4'd0, 1'b0, 64'd0, 64'd0, '0, '0);
        in_valid = 1'b0;
        tick(); tick();
        rst = 1'b0;
        @(negedge clk);
        n_vec++;
        if (out_valid !== 1'b0) begin n_err++; $display("[TB] FAIL reset_out_valid got %0b want 0", out_valid); end
        n_vec++;
        if (in_ready !== 1'b1) begin n_err++; $display("[TB] FAIL reset_in_ready got %0b want 1", in_ready); end
        n_vec++;
        if (wakeup_valid !== 1'b0) begin n_err++; $display("[TB] FAIL reset_wakeup got %0b want 0", wakeup_valid); end
        tick();
    endtask

    task automatic test_add_latency();
        int wake = 0;
        int seen_at = -1;
        out_ready = 1'b1;
        drive(4'd0, 1'b0, 64'd5, 64'd7, '0, 6'd1);
        tick();
        in_valid = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            if (wakeup_valid === 1'b1) wake++;
            if (out_valid === 1'b1 && seen_at < 0) begin
                seen_at = c;
                n_vec++;
                if (out_value !== 64'd12) begin n_err++; $display("[TB] FAIL add_value got %0d want 12", out_value); end
            end
            tick();
        end
        n_vec++;
        if (seen_at != STAGES) begin n_err++; $display("[TB] FAIL add_latency got %0d want %0d", seen_at, STAGES); end
        n_vec++;
        if (wake != 1) begin n_err++; $display("[TB] FAIL add_wakeup_count got %0d want 1", wake); end
    endtask

    task automatic test_directed_ops();
        logic [3:0]  ops  [16];
        logic        wds  [16];
        logic [63:0] as   [16];
        logic [63:0] bs   [16];
        logic [63:0] want [16];
        bit          seen;
        ops = '{4'd0, 4'd7, 4'd15, 4'd10, 4'd12, 4'd14, 4'd3, 4'd4,
                4'd11, 4'd13, 4'd1, 4'd6, 4'd5, 4'd2, 4'd7, 4'd15};
        wds = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        as  = '{64'h7FFFFFFF, 64'h80000000, 64'd1, '1, '1, 64'h8000000000000001, '1, '1,
                '1, '1, 64'd0, 64'hFFFFFFFF80000000, 64'hF000000000000000, 64'h40000000,
                64'h8000000000000000, 64'd1};
        bs  = '{64'd1, 64'd4, 64'd1, 64'd3, 64'd3, 64'd4, 64'd3, 64'd3,
                64'd3, 64'd3, 64'd1, 64'd4, 64'd1, 64'd1, 64'd63, 64'd0};
        want = '{64'hFFFFFFFF80000000, 64'hFFFFFFFFF8000000, 64'hFFFFFFFF80000000, '1,
                 64'd3, 64'h18, 64'd1, 64'd0, 64'd3, '1, '1, 64'h0000000008000000,
                 64'hF000000000000001, 64'hFFFFFFFF80000000, '1, 64'd1};
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            drive(ops[i], wds[i], as[i], bs[i], '0, ROB_W'(i));
            tick();
            in_valid = 1'b0;
            seen = 1'b0;
            for (int c = 0; c < 10 && !seen; c++) begin
                @(negedge clk);
                if (out_valid === 1'b1) begin
                    seen = 1'b1;
                    n_vec++;
                    if (out_value !== want[i])
                        begin n_err++; $display("[TB] FAIL op_%0d op=%0d word=%0b got %h want %h", i, ops[i], wds[i], out_value, want[i]); end
                end
                tick();
            end
            if (!seen) begin n_vec++; n_err++; $display("[TB] FAIL op_%0d_timeout got no out_valid want result", i); end
        end
    endtask

    task automatic test_backpressure();
        logic [63:0] exp_v [4];
        int acc = 0;
        int ret = 0;
        int first_ret = -1;
        int last_ret = -1;
        for (int i = 0; i < 4; i++) exp_v[i] = ref_alu(4'd0, 1'b0, 64'd100 * (i + 1), 64'd1);
        out_ready = 1'b0;
        for (int c = 0; c < 6; c++) begin
            if (acc < 4) drive(4'd0, 1'b0, 64'd100 * (acc + 1), 64'd1, '0, ROB_W'(20 + acc));
            else in_valid = 1'b0;
            @(negedge clk);
            if (c >= STAGES) begin
                n_vec++;
                if (in_ready !== 1'b0) begin n_err++; $display("[TB] FAIL bp_in_ready_c%0d got %0b want 0", c, in_ready); end
                n_vec++;
                if (out_valid !== 1'b1 || out_value !== exp_v[0])
                    begin n_err++; $display("[TB] FAIL bp_hold_c%0d got v=%0b %h want v=1 %h", c, out_valid, out_value, exp_v[0]); end
            end
            if (in_valid && in_ready) acc++;
            tick();
        end
        n_vec++;
        if (acc != STAGES) begin n_err++; $display("[TB] FAIL bp_accepted got %0d want %0d", acc, STAGES); end
        out_ready = 1'b1;
        for (int c = 0; c < 12; c++) begin
            if (acc < 4) drive(4'd0, 1'b0, 64'd100 * (acc + 1), 64'd1, '0, ROB_W'(20 + acc));
            else in_valid = 1'b0;
            @(negedge clk);
            if (out_valid && out_ready) begin
                n_vec++;
                if (ret >= 4 || out_value !== exp_v[ret % 4])
                    begin n_err++; $display("[TB] FAIL bp_drain_%0d got %h want %h", ret, out_value, exp_v[ret % 4]); end
                if (first_ret < 0) first_ret = c;
                last_ret = c;
                ret++;
            end
            if (in_valid && in_ready) acc++;
            tick();
        end
        n_vec++;
        if (ret != 4 || last_ret - first_ret != 3)
            begin n_err++; $display("[TB] FAIL bp_drain_shape got count=%0d span=%0d want count=4 span=3", ret, last_ret - first_ret); end
    endtask

    task automatic test_kill(input bit do_resolve, input logic [SPEC-1:0] km);
        logic [SPEC-1:0] mask_a = 8'b01;
        logic [SPEC-1:0] mask_b = 8'b10;
        logic [ROB_W-1:0] exp_rob [$];
        logic [SPEC-1:0]  exp_msk [$];
        int got = 0;
        if (do_resolve) begin mask_a = mask_a & ~8'b10; mask_b = mask_b & ~8'b10; end
        if ((mask_a & km) == 0) begin exp_rob.push_back(6'd40); exp_msk.push_back(mask_a); end
        if ((mask_b & km) == 0) begin exp_rob.push_back(6'd41); exp_msk.push_back(mask_b); end
        out_ready = 1'b0;
        drive(4'd8, 1'b0, 64'h10, 64'h1, 8'b01, 6'd40);
        tick();
        drive(4'd8, 1'b0, 64'h20, 64'h2, 8'b10, 6'd41);
        tick();
        in_valid = 1'b0;
        if (do_resolve) begin
            resolve_en = 1'b1; resolve_mask = 8'b10;
            tick();
            resolve_en = 1'b0; resolve_mask = '0;
        end
        kill_en = 1'b1; kill_mask = km;
        @(negedge clk);
        n_vec++;
        if (out_valid !== 1'b1) begin n_err++; $display("[TB] FAIL kill_cycle_out_valid got %0b want 1", out_valid); end
        tick();
        kill_en = 1'b0; kill_mask = '0;
        out_ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (out_valid && out_ready) begin
                n_vec++;
                if (got >= exp_rob.size())
                    begin n_err++; $display("[TB] FAIL kill_extra got rob=%0d want none", out_rob); end
                else if (out_rob !== exp_rob[got] || out_killmask !== exp_msk[got])
                    begin n_err++; $display("[TB] FAIL kill_retire_%0d got rob=%0d mask=%b want rob=%0d mask=%b", got, out_rob, out_killmask, exp_rob[got], exp_msk[got]); end
                got++;
            end
            tick();
        end
        n_vec++;
        if (got != exp_rob.size()) begin n_err++; $display("[TB] FAIL kill_count got %0d want %0d", got, exp_rob.size()); end
    endtask

    task automatic test_kill_incoming();
        int seen = 0;
        out_ready = 1'b1;
        drive(4'd0, 1'b0, 64'd1, 64'd1, 8'b100, 6'd50);
        kill_en = 1'b1; kill_mask = 8'b100;
        @(negedge clk);
        n_vec++;
        if (in_ready !== 1'b1) begin n_err++; $display("[TB] FAIL kill_in_ready got %0b want 1", in_ready); end
        tick();
        idle();
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (out_valid === 1'b1) seen++;
            tick();
        end
        n_vec++;
        if (seen != 0) begin n_err++; $display("[TB] FAIL kill_incoming_captured got %0d want 0", seen); end
    endtask

    task automatic test_flush();
        int wakes = 0;
        int valids = 0;
        out_ready = 1'b0;
        drive(4'd0, 1'b0, 64'd1, 64'd2, '0, 6'd60);
        tick();
        drive(4'd0, 1'b0, 64'd3, 64'd4, '0, 6'd61);
        tick();
        drive(4'd0, 1'b0, 64'd5, 64'd6, '0, 6'd62);
        flush = 1'b1;
        tick();
        @(negedge clk);
        n_vec++;
        if (out_valid !== 1'b0) begin n_err++; $display("[TB] FAIL flush_out_valid got %0b want 0", out_valid); end
        n_vec++;
        if (in_ready !== 1'b1) begin n_err++; $display("[TB] FAIL flush_in_ready got %0b want 1", in_ready); end
        tick();
        idle();
        out_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (wakeup_valid === 1'b1) wakes++;
            if (out_valid === 1'b1) valids++;
            tick();
        end
        n_vec++;
        if (wakes != 0 || valids != 0) begin n_err++; $display("[TB] FAIL flush_leak got wakes=%0d valids=%0d want 0 0", wakes, valids); end
    endtask

    task automatic test_random();
        exp_t e;
        logic [63:0] a, b;
        logic [3:0] op;
        logic wd;
        logic [ROB_W-1:0] tag = '0;
        bit prev_stall = 1'b0;
        logic [63:0] prev_val = '0;
        logic [ROB_W-1:0] prev_rob = '0;
        sb.delete();
        for (int c = 0; c < 420; c++) begin
            if (c < 400) begin
                op = 4'($urandom_range(0, 15));
                wd = 1'($urandom % 2);
                a  = ($urandom % 4 == 0) ? 64'($urandom_range(0, 70)) : {$urandom, $urandom};
                b  = ($urandom % 4 == 0) ? 64'($urandom_range(0, 70)) : {$urandom, $urandom};
                drive(op, wd, a, b, '0, tag);
                in_valid  = ($urandom % 4) != 0;
                out_ready = ($urandom % 3) != 0;
            end else begin
                in_valid  = 1'b0;
                out_ready = 1'b1;
            end
            @(negedge clk);
            n_vec++;
            if (in_ready !== ((sb.size() < STAGES) || out_ready))
                begin n_err++; $display("[TB] FAIL rnd_in_ready c%0d got %0b want %0b", c, in_ready, (sb.size() < STAGES) || out_ready); end
            n_vec++;
            if (wakeup_valid !== (out_valid && out_ready))
                begin n_err++; $display("[TB] FAIL rnd_wakeup c%0d got %0b want %0b", c, wakeup_valid, out_valid && out_ready); end
            if (prev_stall) begin
                n_vec++;
                if (out_valid !== 1'b1 || out_value !== prev_val || out_rob !== prev_rob)
                    begin n_err++; $display("[TB] FAIL rnd_stable c%0d got %h/%0d want %h/%0d", c, out_value, out_rob, prev_val, prev_rob); end
            end
            prev_stall = out_valid && !out_ready;
            prev_val = out_value;
            prev_rob = out_rob;
            if (out_valid && out_ready) begin
                n_vec++;
                if (sb.size() == 0) begin
                    n_err++; $display("[TB] FAIL rnd_unexpected c%0d got rob=%0d want nothing", c, out_rob);
                end else begin
                    e = sb.pop_front();
                    if (out_value !== e.value || out_rob !== e.rob || out_prd !== e.prd)
                        begin n_err++; $display("[TB] FAIL rnd_result c%0d got %h rob=%0d prd=%0d want %h rob=%0d prd=%0d", c, out_value, out_rob, out_prd, e.value, e.rob, e.prd); end
                end
            end
            if (in_valid && in_ready) begin
                e.value = ref_alu(in_op, in_word, in_op1, in_op2);
                e.rob = in_rob;
                e.prd = in_prd;
                sb.push_back(e);
                tag++;
            end
            tick();
        end
        n_vec++;
        if (sb.size() != 0) begin n_err++; $display("[TB] FAIL rnd_lost got %0d pending want 0", sb.size()); end
    endtask

    initial begin
        test_reset();
        test_add_latency();
        test_directed_ops();
        test_backpressure();
        idle();
        test_kill(1'b0, 8'b10);
        test_kill(1'b1, 8'b10);
        test_kill(1'b0, 8'b01);
        test_kill_incoming();
        test_flush();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
